// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring divider on operand magnitudes; signs are fixed up in a final cycle.
module div_unit #(
    parameter int WIDTH        = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic             I_clk,
    input  logic             I_reset,
    input  logic             I_en,
    input  logic [WIDTH-1:0] I_dataS1,
    input  logic [WIDTH-1:0] I_dataS2,
    input  logic [1:0]       I_divop,
    output logic             O_busy,
    output logic             O_valid,
    output logic [WIDTH-1:0] O_data
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN,
        ST_FAST
    } state_t;

    // Handshake: a request is taken on a rising edge where I_en=1 and O_busy=0;
    // O_valid pulses for exactly one cycle with O_busy=0, so a new request may be
    // taken in that same cycle. I_en while O_busy=1 is dropped.
    state_t           state_q, state_d;
    logic             is_rem_q, is_rem_d;
    logic             neg1_q, neg1_d;
    logic             neg2_q, neg2_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic             signed_op, a_neg, b_neg, is_zero, is_ovf, q_bit;
    logic [WIDTH-1:0] abs_a, abs_b, rem_sub, quo_fix, rem_fix;
    logic [WIDTH:0]   rem_shift;

    always_comb begin
        signed_op = ~I_divop[0];
        a_neg     = signed_op & I_dataS1[WIDTH-1];
        b_neg     = signed_op & I_dataS2[WIDTH-1];
        abs_a     = a_neg ? -I_dataS1 : I_dataS1;
        abs_b     = b_neg ? -I_dataS2 : I_dataS2;
        is_zero   = (I_dataS2 == '0);
        is_ovf    = signed_op && (I_dataS1 == MIN_NEG) && (I_dataS2 == '1);

        // rem < dvs holds every step, so the low WIDTH bits of the difference suffice
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dvs_q});
        rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;

        // A zero divisor must still give all-ones, so the quotient sign fix-up is skipped
        quo_fix   = ((neg1_q ^ neg2_q) && (dvs_q != '0)) ? -dvd_q : dvd_q;
        rem_fix   = neg1_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        is_rem_d = is_rem_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (I_en) begin
                    is_rem_d = I_divop[1];
                    neg1_d   = a_neg;
                    neg2_d   = b_neg;
                    dvd_d    = abs_a;
                    dvs_d    = abs_b;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                    if (FAST_SPECIAL && (is_zero || is_ovf)) begin
                        // Results are final here; FAST just publishes them unmodified
                        dvd_d   = is_zero ? '1 : MIN_NEG;
                        rem_d   = is_zero ? I_dataS1 : '0;
                        neg1_d  = 1'b0;
                        neg2_d  = 1'b0;
                        state_d = ST_FAST;
                    end
                end
            end
            ST_RUN: begin
                rem_d = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                data_d  = is_rem_q ? rem_fix : quo_fix;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAST: begin
                data_d  = is_rem_q ? rem_q : dvd_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q  <= ST_IDLE;
            is_rem_q <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_rem_q <= is_rem_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign O_busy  = (state_q != ST_IDLE);
    assign O_valid = valid_q;
    assign O_data  = data_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: one instance with the fast special-case path,
// one without, sharing operands and reset but with separate start strobes.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1, en2;
    logic [31:0] s1, s2;
    logic [1:0]  op;
    logic        busy1, valid1, busy2, valid2;
    logic [31:0] data1, data2;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut_fast (
        .I_clk(clk), .I_reset(rst), .I_en(en1), .I_dataS1(s1), .I_dataS2(s2),
        .I_divop(op), .O_busy(busy1), .O_valid(valid1), .O_data(data1)
    );

    div_unit #(.WIDTH(32), .FAST_SPECIAL(1'b0)) dut_slow (
        .I_clk(clk), .I_reset(rst), .I_en(en2), .I_dataS1(s1), .I_dataS2(s2),
        .I_divop(op), .O_busy(busy2), .O_valid(valid2), .O_data(data2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts an op right after a falling edge; returns right after sampling the
    // result cycle, so consecutive calls are back-to-back requests.
    task automatic run_op(input int which, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input string tag, input bit inject);
        int          bad;
        logic        bz, vl;
        logic [31:0] dt;
        bad = 0;
        op = o; s1 = a; s2 = b;
        if (which == 0) en1 = 1'b1; else en2 = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            bz = (which == 0) ? busy1 : busy2;
            vl = (which == 0) ? valid1 : valid2;
            dt = (which == 0) ? data1 : data2;
            if (k == 1) begin
                en1 = 1'b0; en2 = 1'b0;
                s1 = $urandom; s2 = $urandom; op = 2'($urandom_range(0, 3));
            end
            if (k < lat && (bz !== 1'b1 || vl !== 1'b0)) bad++;
            if (inject && k == 10) begin
                en1 = 1'b1; s1 = 32'd1000; s2 = 32'd0; op = DIVU;
            end
            if (inject && k == 11) en1 = 1'b0;
            if (k == lat) begin
                check({tag, "_win"}, 32'(bad), 32'd0);
                check({tag, "_valid"}, {31'b0, vl}, 32'd1);
                check({tag, "_busy"}, {31'b0, bz}, 32'd0);
                check(tag, dt, exp_q.pop_front());
            end
        end
    endtask

    typedef struct {
        int          which;
        logic [1:0]  o;
        logic [31:0] a, b, exp;
        int          lat;
        string       tag;
    } vec_t;

    vec_t vecs[] = '{
        '{0, DIV,  32'd100,        32'd7,          32'd14,         34, "div_100_7"},
        '{0, REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34, "rem_m7_2"},
        '{0, DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   34, "div_m7_2"},
        '{0, DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   34, "divu_max_1"},
        '{0, DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   34, "div_100_m7"},
        '{0, REM,  32'd100,        32'hFFFFFFF9,   32'd2,          34, "rem_100_m7"},
        '{0, REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   34, "rem_m100_7"},
        '{0, DIVU, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   34, "divu_max_16"},
        '{0, REMU, 32'hFFFFFFFF,   32'h10,         32'h0000000F,   34, "remu_max_16"},
        '{0, DIVU, 32'd7,          32'd9,          32'd0,          34, "divu_7_9"},
        '{0, REMU, 32'd7,          32'd9,          32'd7,          34, "remu_7_9"},
        '{0, DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,    2, "divu_5_0_f"},
        '{0, REMU, 32'd5,          32'd0,          32'd5,           2, "remu_5_0_f"},
        '{0, DIV,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,    2, "div_m7_0_f"},
        '{0, REM,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,    2, "rem_m7_0_f"},
        '{0, DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,    2, "div_ovf_f"},
        '{0, REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,           2, "rem_ovf_f"},
        '{1, DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   34, "divu_5_0_s"},
        '{1, REMU, 32'd5,          32'd0,          32'd5,          34, "remu_5_0_s"},
        '{1, DIV,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   34, "div_m7_0_s"},
        '{1, REM,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   34, "rem_m7_0_s"},
        '{1, DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   34, "div_ovf_s"},
        '{1, REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          34, "rem_ovf_s"}
    };

    initial begin
        int vcount;
        rst = 1'b1; en1 = 1'b0; en2 = 1'b0; s1 = '0; s2 = '0; op = DIV;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy1",  {31'b0, busy1},  32'd0);
        check("rst_valid1", {31'b0, valid1}, 32'd0);
        check("rst_data1",  data1,           32'd0);
        check("rst_busy2",  {31'b0, busy2},  32'd0);
        check("rst_data2",  data2,           32'd0);

        foreach (vecs[i])
            run_op(vecs[i].which, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].lat, vecs[i].tag, 1'b0);

        // Mid-op request is dropped; the following request lands in the O_valid cycle
        run_op(0, DIV,  32'd100, 32'd7, 32'd14, 34, "inject_div", 1'b1);
        run_op(0, REMU, 32'd100, 32'd7, 32'd2,  34, "b2b_remu",   1'b0);

        // Reset in the middle of a divide
        op = DIV; s1 = 32'd1000; s2 = 32'd3; en1 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) en1 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",  {31'b0, busy1},  32'd0);
        check("abort_valid", {31'b0, valid1}, 32'd0);
        check("abort_data",  data1,           32'd0);
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid1 !== 1'b0 || busy1 !== 1'b0) vcount++;
        end
        check("abort_quiet", 32'(vcount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
